// File: rtl/pipa_counter_scheduler_if.sv
// PIPA pulse inputs and counter-request handshake between the PIPA interface,
// the scheduler and the control sequencer.
interface pipa_counter_scheduler_if;
  logic       PIPAXp;
  logic       PIPAXm;
  logic       PIPAYp;
  logic       PIPAYm;
  logic       PIPAZp;
  logic       PIPAZm;
  logic       PIPSAM;
  logic       CTROPP;
  logic       FLCLR;
  logic       ctr_req;
  logic [5:0] ctr_addr;
  logic       PINC;
  logic       MINC;
  logic       PIPAFL;

  modport slave (
    input  PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm,
    input  PIPSAM, CTROPP, FLCLR,
    output ctr_req, ctr_addr, PINC, MINC, PIPAFL
  );

  modport master (
    output PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm,
    output PIPSAM, CTROPP, FLCLR,
    input  ctr_req, ctr_addr, PINC, MINC, PIPAFL
  );
endinterface

// File: rtl/pipa_counter_scheduler.sv
// Turns sampled PIPA pulses into per-axis net pending counts and issues one
// PINC/MINC counter cycle at a time to the sequencer, X before Y before Z.
module pipa_counter_scheduler #(
  parameter logic [5:0] ADDR_X = 6'o37,
  parameter logic [5:0] ADDR_Y = 6'o40,
  parameter logic [5:0] ADDR_Z = 6'o41
) (
  input  logic                    CLOCK,
  input  logic                    rst,
  pipa_counter_scheduler_if.slave bus
);
  localparam int unsigned N_AXES = 3;
  localparam int unsigned PIN_W  = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SUM_W  = 4;
  localparam int unsigned AX_W   = 2;
  localparam int unsigned ADDR_W = 6;
  localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'(3);
  localparam logic signed [SUM_W-1:0] CNT_MIN = SUM_W'(-3);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [PIN_W-1:0]        w_pins, r_sync1, r_sync2;
  logic signed [CNT_W-1:0] r_cnt     [N_AXES];
  logic signed [CNT_W-1:0] w_cnt_nxt [N_AXES];
  logic signed [SUM_W-1:0] w_samp    [N_AXES];
  logic signed [SUM_W-1:0] w_svc     [N_AXES];
  logic signed [SUM_W-1:0] w_sum     [N_AXES];
  logic [N_AXES-1:0]       w_illegal, w_sat;
  logic                    w_grant, w_any, w_fault_set;

  logic [AX_W-1:0]   r_axis, w_axis_nxt;
  logic              r_dir, w_dir_nxt;
  logic              r_ctr_req, w_req_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_pinc, w_pinc_nxt;
  logic              r_minc, w_minc_nxt;
  logic              r_fl, w_fl_nxt;

  assign w_pins = {bus.PIPAXp, bus.PIPAXm, bus.PIPAYp, bus.PIPAYm, bus.PIPAZp, bus.PIPAZm};

  // Two-flop synchronizer on every raw PIPA line
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
    end
  end

  assign w_grant = (r_state == S_REQ) && bus.CTROPP;
  assign w_any   = (r_cnt[0] != '0) || (r_cnt[1] != '0) || (r_cnt[2] != '0);

  // Sample and service folded into one saturating step per axis
  always_comb begin
    for (int unsigned a = 0; a < N_AXES; a++) begin
      w_samp[a]    = '0;
      w_svc[a]     = '0;
      w_illegal[a] = 1'b0;
      w_sat[a]     = 1'b0;
      if (bus.PIPSAM) begin
        case ({r_sync2[PIN_W-1-2*a], r_sync2[PIN_W-2-2*a]})
          2'b10:   w_samp[a] = SUM_W'(1);
          2'b01:   w_samp[a] = SUM_W'(-1);
          2'b11:   w_illegal[a] = 1'b1;
          default: w_samp[a] = '0;
        endcase
      end
      if (w_grant && (r_axis == AX_W'(a))) begin
        w_svc[a] = r_dir ? SUM_W'(1) : SUM_W'(-1);
      end
      w_sum[a] = SUM_W'(r_cnt[a]) + w_samp[a] - w_svc[a];
      if (w_sum[a] > CNT_MAX) begin
        w_cnt_nxt[a] = CNT_W'(CNT_MAX);
        w_sat[a]     = 1'b1;
      end else if (w_sum[a] < CNT_MIN) begin
        w_cnt_nxt[a] = CNT_W'(CNT_MIN);
        w_sat[a]     = 1'b1;
      end else begin
        w_cnt_nxt[a] = CNT_W'(w_sum[a]);
      end
    end
  end

  assign w_fault_set = (|w_illegal) || (|w_sat);

  always_comb begin
    w_fl_nxt = r_fl;
    if (w_fault_set) begin
      w_fl_nxt = 1'b1;
    end else if (bus.FLCLR) begin
      w_fl_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      for (int unsigned a = 0; a < N_AXES; a++) begin
        r_cnt[a] <= '0;
      end
      r_fl <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < N_AXES; a++) begin
        r_cnt[a] <= w_cnt_nxt[a];
      end
      r_fl <= w_fl_nxt;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_state_nxt = S_REQ;
      S_REQ:     if (bus.CTROPP) w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Request selection is latched on leaving IDLE and held through REQ
  always_comb begin
    w_axis_nxt = r_axis;
    w_dir_nxt  = r_dir;
    if ((r_state == S_IDLE) && w_any) begin
      if (r_cnt[0] != '0) begin
        w_axis_nxt = AX_W'(0);
        w_dir_nxt  = ~r_cnt[0][CNT_W-1];
      end else if (r_cnt[1] != '0) begin
        w_axis_nxt = AX_W'(1);
        w_dir_nxt  = ~r_cnt[1][CNT_W-1];
      end else begin
        w_axis_nxt = AX_W'(2);
        w_dir_nxt  = ~r_cnt[2][CNT_W-1];
      end
    end
    w_req_nxt  = (w_state_nxt == S_REQ);
    w_pinc_nxt = w_req_nxt && w_dir_nxt;
    w_minc_nxt = w_req_nxt && !w_dir_nxt;
    w_addr_nxt = '0;
    if (w_req_nxt) begin
      case (w_axis_nxt)
        AX_W'(0): w_addr_nxt = ADDR_X;
        AX_W'(1): w_addr_nxt = ADDR_Y;
        default:  w_addr_nxt = ADDR_Z;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      r_axis    <= '0;
      r_dir     <= 1'b0;
      r_ctr_req <= 1'b0;
      r_addr    <= '0;
      r_pinc    <= 1'b0;
      r_minc    <= 1'b0;
    end else begin
      r_axis    <= w_axis_nxt;
      r_dir     <= w_dir_nxt;
      r_ctr_req <= w_req_nxt;
      r_addr    <= w_addr_nxt;
      r_pinc    <= w_pinc_nxt;
      r_minc    <= w_minc_nxt;
    end
  end

  assign bus.ctr_req  = r_ctr_req;
  assign bus.ctr_addr = r_addr;
  assign bus.PINC     = r_pinc;
  assign bus.MINC     = r_minc;
  assign bus.PIPAFL   = r_fl;
endmodule

// File: tb/tb_pipa_counter_scheduler.sv
// Directed bench for pipa_counter_scheduler: a per-cycle reference model of
// pending counts and request issue, plus hand-computed grant logs.
module tb_pipa_counter_scheduler;
  logic CLOCK = 1'b0;
  logic rst;

  pipa_counter_scheduler_if bus();

  pipa_counter_scheduler #(
    .ADDR_X(6'o37),
    .ADDR_Y(6'o40),
    .ADDR_Z(6'o41)
  ) dut (
    .CLOCK(CLOCK),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  bit [5:0] m_h1, m_h2;
  int       m_cnt [3];
  bit       m_req;
  int       m_axis;
  int       m_dir;
  bit       m_quiet;
  bit       m_fl;

  typedef struct {
    logic [5:0] addr;
    bit         inc;
    int         cyc;
  } grant_t;
  grant_t glog[$];

  wire [5:0] w_pins = {bus.PIPAXp, bus.PIPAXm, bus.PIPAYp, bus.PIPAYm, bus.PIPAZp, bus.PIPAZm};

  function automatic logic [5:0] addr_of(input int a);
    case (a)
      0:       return 6'o37;
      1:       return 6'o40;
      default: return 6'o41;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Model: net pending counts with clamping, one outstanding request, two dead cycles
  always @(posedge CLOCK or posedge rst) begin : model
    int  nc [3];
    int  v, samp;
    bit  fset, grant, p, m, found;
    if (rst) begin
      m_h1    <= '0;
      m_h2    <= '0;
      m_cnt   <= '{0, 0, 0};
      m_req   <= 1'b0;
      m_axis  <= 0;
      m_dir   <= 0;
      m_quiet <= 1'b0;
      m_fl    <= 1'b0;
    end else begin
      fset  = 1'b0;
      grant = m_req && bus.CTROPP;
      for (int a = 0; a < 3; a++) begin
        p    = m_h2[5-2*a];
        m    = m_h2[4-2*a];
        samp = 0;
        if (bus.PIPSAM) begin
          if (p && !m) samp = 1;
          else if (!p && m) samp = -1;
          else if (p && m) fset = 1'b1;
        end
        v = m_cnt[a] + samp - ((grant && a == m_axis) ? m_dir : 0);
        if (v > 3) begin v = 3; fset = 1'b1; end
        if (v < -3) begin v = -3; fset = 1'b1; end
        nc[a] = v;
      end
      m_cnt <= nc;
      if (m_req) begin
        if (grant) begin
          m_req   <= 1'b0;
          m_quiet <= 1'b1;
        end
      end else if (m_quiet) begin
        m_quiet <= 1'b0;
      end else begin
        found = 1'b0;
        for (int a = 0; a < 3; a++) begin
          if (!found && m_cnt[a] != 0) begin
            found = 1'b1;
            m_req  <= 1'b1;
            m_axis <= a;
            m_dir  <= (m_cnt[a] > 0) ? 1 : -1;
          end
        end
      end
      m_fl <= fset ? 1'b1 : (bus.FLCLR ? 1'b0 : m_fl);
      m_h1 <= w_pins;
      m_h2 <= m_h1;
    end
  end

  // Per-cycle output compare and DUT grant log
  always @(negedge CLOCK) begin : compare
    logic [9:0] got, want;
    got  = {bus.ctr_req, bus.ctr_addr, bus.PINC, bus.MINC, bus.PIPAFL};
    want = {m_req, m_req ? addr_of(m_axis) : 6'd0, m_req && (m_dir > 0), m_req && (m_dir < 0), m_fl};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle_outputs t=%0t got req=%b addr=%o pinc=%b minc=%b fl=%b want req=%b addr=%o pinc=%b minc=%b fl=%b",
               $time, got[9], got[8:3], got[2], got[1], got[0],
               want[9], want[8:3], want[2], want[1], want[0]);
    end
    if (bus.ctr_req === 1'b1 && bus.CTROPP === 1'b1) begin
      glog.push_back('{addr: bus.ctr_addr, inc: bus.PINC, cyc: cyc});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic set_pins(input bit [5:0] v);
    {bus.PIPAXp, bus.PIPAXm, bus.PIPAYp, bus.PIPAYm, bus.PIPAZp, bus.PIPAZm} = v;
  endtask

  // Hold pins long enough to cross the synchronizer, then strobe PIPSAM once
  task automatic sample(input bit [5:0] v, input bit clr = 1'b0);
    set_pins(v);
    step(2);
    bus.PIPSAM = 1'b1;
    bus.FLCLR  = clr;
    step(1);
    bus.PIPSAM = 1'b0;
    bus.FLCLR  = 1'b0;
    set_pins(6'b0);
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!m_req && !m_quiet && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0) begin
        done = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    set_pins(6'b0);
    bus.PIPSAM = 1'b0;
    bus.CTROPP = 1'b0;
    bus.FLCLR  = 1'b0;
    #1;
    check("reset_outputs", 32'({bus.ctr_req, bus.ctr_addr, bus.PINC, bus.MINC, bus.PIPAFL}), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);

    // Single X+ pulse, grant tied high
    bus.CTROPP = 1'b1;
    sample(6'b100000);
    drain("x_single_drain", 20);
    step(2);
    check("x_single_count", 32'(glog.size()), 32'd1);
    if (glog.size() == 1) begin
      check("x_single_addr", 32'(glog[0].addr), 32'o37);
      check("x_single_inc", 32'(glog[0].inc), 32'd1);
    end
    check("x_single_model_cnt", 32'(m_cnt[0]), 32'd0);
    check("x_single_fl", 32'(bus.PIPAFL), 32'd0);
    glog.delete();

    // X-, Y+, Z+ together: served X, Y, Z with two dead cycles between
    sample(6'b011010);
    drain("prio_drain", 30);
    step(2);
    check("prio_count", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      check("prio_0", 32'({glog[0].addr, glog[0].inc}), 32'({6'o37, 1'b0}));
      check("prio_1", 32'({glog[1].addr, glog[1].inc}), 32'({6'o40, 1'b1}));
      check("prio_2", 32'({glog[2].addr, glog[2].inc}), 32'({6'o41, 1'b1}));
      check("prio_gap_01", 32'(glog[1].cyc - glog[0].cyc), 32'd3);
      check("prio_gap_12", 32'(glog[2].cyc - glog[1].cyc), 32'd3);
    end
    glog.delete();

    // Y+ request held, Y- arrives, grant still delivers PINC then a MINC follows
    bus.CTROPP = 1'b0;
    sample(6'b001000);
    step(2);
    check("cancel_req", 32'({bus.ctr_req, bus.ctr_addr, bus.PINC}), 32'({1'b1, 6'o40, 1'b1}));
    sample(6'b000100);
    check("cancel_model_cnt", 32'(m_cnt[1]), 32'd0);
    bus.CTROPP = 1'b1;
    drain("cancel_drain", 20);
    step(2);
    check("cancel_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      check("cancel_0", 32'({glog[0].addr, glog[0].inc}), 32'({6'o40, 1'b1}));
      check("cancel_1", 32'({glog[1].addr, glog[1].inc}), 32'({6'o40, 1'b0}));
    end
    glog.delete();

    // Four Z+ samples saturate at +3 and flag a lost pulse
    bus.CTROPP = 1'b0;
    repeat (4) sample(6'b000010);
    check("sat_model_cnt", 32'(m_cnt[2]), 32'd3);
    check("sat_fl", 32'(bus.PIPAFL), 32'd1);
    bus.CTROPP = 1'b1;
    drain("sat_drain", 40);
    step(2);
    check("sat_count", 32'(glog.size()), 32'd3);
    foreach (glog[i]) check("sat_entry", 32'({glog[i].addr, glog[i].inc}), 32'({6'o41, 1'b1}));
    glog.delete();
    bus.CTROPP = 1'b0;
    bus.FLCLR  = 1'b1;
    step(1);
    bus.FLCLR  = 1'b0;
    check("sat_flclr", 32'(bus.PIPAFL), 32'd0);

    // Illegal X pair: flag only, no count, no request; set wins over FLCLR
    bus.CTROPP = 1'b1;
    sample(6'b110000);
    step(4);
    check("illegal_fl", 32'(bus.PIPAFL), 32'd1);
    check("illegal_no_req", 32'(glog.size()), 32'd0);
    check("illegal_model_cnt", 32'(m_cnt[0]), 32'd0);
    bus.FLCLR = 1'b1;
    step(1);
    bus.FLCLR = 1'b0;
    check("illegal_clr", 32'(bus.PIPAFL), 32'd0);
    sample(6'b110000, 1'b1);
    check("illegal_set_beats_clr", 32'(bus.PIPAFL), 32'd1);
    bus.FLCLR = 1'b1;
    step(1);
    bus.FLCLR = 1'b0;

    // Reset while a request is outstanding drops it with no count update
    bus.CTROPP = 1'b0;
    sample(6'b100000);
    step(2);
    check("rst_pre_req", 32'(bus.ctr_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'({bus.ctr_req, bus.ctr_addr, bus.PINC, bus.MINC, bus.PIPAFL}), 32'd0);
    bus.CTROPP = 1'b1;
    step(2);
    rst = 1'b0;
    step(8);
    check("rst_no_req_after", 32'(bus.ctr_req), 32'd0);
    check("rst_no_grant", 32'(glog.size()), 32'd0);
    check("rst_model_cnt", 32'(m_cnt[0] + m_cnt[1] + m_cnt[2]), 32'd0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
